fft_output_serializer: RTL
==========================

// Module: fft_output_serializer
// PURPOSE
//  Receiving end of the parallel FFT datapath: captures one 32-point frame of complex results
//  presented in parallel by the last butterfly stage, then streams it out one complex word per
//  beat over a valid/ready interface, optionally reordered from bit-reversed to natural order.
//  Double-buffered (ping-pong), so a new frame is accepted while the previous one drains.
// PARAMETERS
//  p_dataBits    30  complex word width; [p_dataBits-1:p_dataBits/2]=real, [p_dataBits/2-1:0]=imag
//  p_points      32  frame length (power of two); p_idxBits=$clog2(p_points) derived localparam
//  p_bitReverse  1   1: output frame[bitrev(n)] at beat n; 0: output frame[n] at beat n
// PORTS
//  CLK        in   1                    system clock, rising edge
//  RST        in   1                    reset, asynchronous, active-low
//  i_valid    in   1                    frame strobe: i_frame holds a complete result frame this cycle
//  i_frame    in   p_points*p_dataBits  packed frame; word k = i_frame[k*p_dataBits +: p_dataBits]
//  o_inReady  out  1                    at least one bank empty; frame captured iff i_valid&&o_inReady
//  o_drop     out  1                    1-cycle pulse: i_valid seen while o_inReady=0 (frame lost)
//  o_valid    out  1                    o_data/o_index/o_last are valid
//  i_ready    in   1                    downstream accepts beat when o_valid&&i_ready
//  o_data     out  p_dataBits           current complex word
//  o_index    out  p_idxBits            natural-order bin index n of o_data
//  o_last     out  1                    high with the beat n=p_points-1
// BEHAVIOUR
//  - Reset (RST=0, async): both bank flags empty, wr/rd bank pointers=0, beat counter=0;
//    o_valid=0, o_drop=0, o_last=0, o_index=0, o_data=0, o_inReady=1. Frame contents not cleared.
//  - o_inReady = !full[wrBank]; depends only on registered flags, never on i_valid or i_ready.
//  - Capture: on edge with i_valid&&o_inReady -> bank[wrBank]<=i_frame, full[wrBank]<=1, wrBank^=1.
//  - Read FSM: IDLE (o_valid=0) -> STREAM when full[rdBank]. Registered outputs: o_valid rises the
//    cycle after capture edge (latency 1 clock from i_valid to first o_valid).
//  - STREAM: beat n presents bank[rdBank][p_bitReverse ? bitrev(n) : n]; o_index=n.
//    Outputs held stable while o_valid&&!i_ready. On handshake n++; at n=p_points-1 handshake:
//    full[rdBank]<=0, rdBank^=1, n<=0; stay in STREAM (no bubble) if other bank full, else IDLE.
//  - Simultaneous last-beat handshake and capture into the other bank: both take effect; flags are
//    per-bank so no conflict. Capture while both full: not possible (o_inReady=0) -> o_drop=1.
//  - A bank is never overwritten while full; ordering is strictly FIFO, frame-granular.
//  - No arithmetic: words pass bit-exact; no saturation, rounding or sign manipulation.
//  - Reset mid-frame: stream aborted immediately; partially sent frame and any queued frame lost.
// STRUCTURE
//  - Shared include fft_defs.vh: FFT_POINTS, FFT_DATA_BITS (=30), FFT_IDX_BITS, bitrev function.
//  - One sub-module: fft_frame_bank (one frame register + full flag, write port, indexed read mux);
//    instantiated twice. Top holds pointers, beat counter, FSM and output registers.
// TESTING
//  1 Reset: hold RST=0, drive i_valid=1 -> o_valid=0, o_drop=0, o_inReady=1; no capture.
//  2 Ramp, p_bitReverse=1: word k=k, i_ready=1 -> 32 beats, o_data 0,16,8,24,4,...,31; o_index
//    0..31; o_last only on beat 31; o_valid first high 1 cycle after capture.
//  3 Backpressure: i_ready toggled 1010.. -> each word held until accepted, no loss/duplication.
//  4 Back-to-back: frame A (k), frame B (k+100) 1 cycle apart, i_ready=1 -> 64 consecutive beats,
//    no bubble; B beat 0 = 100 follows A beat 31 = 31.
//  5 Overflow: i_ready=0, send 3 frames -> first two captured, third gives o_drop=1 for 1 cycle;
//    release i_ready -> exactly 64 beats, frames 1 then 2.
//  6 Reset mid-stream: RST=0 at beat 10 -> o_valid=0 asynchronously; after release next frame
//    streams from n=0 with correct data.

Source files
------------

// File: rtl/fft_output_serializer_pkg.sv
// Shared definitions for the FFT output serializer.
//   FFT_POINTS     frame length (power of two)
//   FFT_DATA_BITS  complex word width (real in the upper half, imag in the lower half)
//   FFT_IDX_BITS   bin index width
//   rd_state_t     read-side FSM states
//   bitrev()       reverses the low nbits bits of a bin index
package fft_output_serializer_pkg;

  localparam int FFT_POINTS    = 32;
  localparam int FFT_DATA_BITS = 30;
  localparam int FFT_IDX_BITS  = $clog2(FFT_POINTS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r = r | (((v >> i) & 32'd1) << (nbits - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_serializer_frame_bank.sv
// One frame buffer of the ping-pong pair: a full frame register plus its full flag.
//   clk, rst_n  clock, asynchronous active-low reset (clears the flag only)
//   wr_en       load wr_frame into the buffer and mark it full
//   wr_frame    packed frame, word k at [k*DATA_BITS +: DATA_BITS]
//   clr         mark the buffer empty (its last word has been sent)
//   rd_idx      word address for the read mux
//   full        buffer holds an unsent frame
//   rd_word     word at rd_idx
module fft_output_serializer_frame_bank #(
  parameter int DATA_BITS = 30,
  parameter int POINTS    = 32,
  parameter int IDX_BITS  = $clog2(POINTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [POINTS*DATA_BITS-1:0] wr_frame,
  input  logic                        clr,
  input  logic [IDX_BITS-1:0]         rd_idx,
  output logic                        full,
  output logic [DATA_BITS-1:0]        rd_word
);

  logic [DATA_BITS-1:0] mem [POINTS];

  // Frame contents are deliberately left out of reset; only the flag matters.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < POINTS; k++) begin
        mem[k] <= wr_frame[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // The writer only targets an empty bank and the reader only clears a full
  // one, so wr_en and clr never meet on the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

  assign rd_word = mem[rd_idx];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures one parallel FFT result frame and streams it out one complex word
// per beat, optionally reordered from bit-reversed to natural order. Two frame
// banks in ping-pong so a new frame can land while the previous one drains.
//   CLK, RST   clock, asynchronous active-low reset
//   i_valid    i_frame holds a complete frame this cycle
//   i_frame    packed frame, word k at [k*p_dataBits +: p_dataBits]
//   o_inReady  write bank is empty; frame captured iff i_valid && o_inReady
//   o_drop     one-cycle pulse after a frame was offered while o_inReady=0
//   o_valid    o_data/o_index/o_last valid
//   i_ready    downstream accepts the beat
//   o_data     current complex word
//   o_index    natural-order bin index of o_data
//   o_last     high on the final beat of a frame
//   dbg_state  read FSM state (0 idle, 1 streaming)
//
// Handshake: a beat transfers on a rising edge where o_valid && i_ready; while
// o_valid && !i_ready every output is held unchanged. o_inReady is derived
// from registered bank flags only, never from i_valid or i_ready.
module fft_output_serializer
  import fft_output_serializer_pkg::*;
#(
  parameter int p_dataBits   = FFT_DATA_BITS,
  parameter int p_points     = FFT_POINTS,
  parameter bit p_bitReverse = 1'b1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           i_valid,
  input  logic [p_points*p_dataBits-1:0] i_frame,
  output logic                           o_inReady,
  output logic                           o_drop,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [p_dataBits-1:0]          o_data,
  output logic [$clog2(p_points)-1:0]    o_index,
  output logic                           o_last,
  output logic                           dbg_state
);

  localparam int p_idxBits = $clog2(p_points);
  localparam logic [p_idxBits-1:0] LAST_BEAT = p_idxBits'(p_points - 1);

  rd_state_t             state;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [p_idxBits-1:0]  beat;
  logic [1:0]            full;
  logic [p_dataBits-1:0] bank_word [2];

  logic                  cap;
  logic                  hs;
  logic                  last_hs;
  logic                  advance;
  logic                  next_rd_bank;
  logic [p_idxBits-1:0]  next_beat;
  logic [p_idxBits-1:0]  rd_addr;
  logic                  src_bank;
  logic                  src_bypass;

  assign o_inReady = !full[wr_bank];
  assign o_index   = beat;
  assign dbg_state = state;

  always_comb begin
    cap          = i_valid && o_inReady;
    hs           = o_valid && i_ready;
    last_hs      = hs && (beat == LAST_BEAT);
    // Load a new output word whenever nothing is on display or the current one is taken.
    advance      = (state == ST_IDLE) || hs;
    next_rd_bank = last_hs ? !rd_bank : rd_bank;
    next_beat    = last_hs ? '0 : (hs ? beat + p_idxBits'(1) : beat);
    rd_addr      = p_bitReverse ? p_idxBits'(bitrev(32'(next_beat), p_idxBits)) : next_beat;
    src_bank     = full[next_rd_bank];
    // A frame landing this very edge in the bank about to be read can be shown
    // straight from i_frame; that only happens at beat 0, whose address is 0
    // in either ordering.
    src_bypass   = cap && (wr_bank == next_rd_bank);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic this_wr;
    logic this_rd;
    assign this_wr = (b == 0) ? !wr_bank : wr_bank;
    assign this_rd = (b == 0) ? !rd_bank : rd_bank;

    fft_output_serializer_frame_bank #(
      .DATA_BITS (p_dataBits),
      .POINTS    (p_points),
      .IDX_BITS  (p_idxBits)
    ) u_bank (
      .clk      (CLK),
      .rst_n    (RST),
      .wr_en    (cap && this_wr),
      .wr_frame (i_frame),
      .clr      (last_hs && this_rd),
      .rd_idx   (rd_addr),
      .full     (full[b]),
      .rd_word  (bank_word[b])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      beat    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_drop  <= i_valid && !o_inReady;
      rd_bank <= next_rd_bank;
      if (cap) begin
        wr_bank <= !wr_bank;
      end
      if (advance) begin
        beat <= next_beat;
        if (src_bank || src_bypass) begin
          state   <= ST_STREAM;
          o_valid <= 1'b1;
          o_data  <= src_bank ? bank_word[next_rd_bank] : i_frame[p_dataBits-1:0];
          o_last  <= (next_beat == LAST_BEAT);
        end else begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
    end
  end

endmodule
